// File: rtl/mm_r2mm_un.sv
// -----------------------------------------------------------------------------
// mm_r2mm_un -- radix-2 Montgomery multiplier, res = x*y*2^-K mod m.
//
// U radix-2 iterations are chained combinationally per clock, so one op takes
// K/U iteration cycles plus one cycle for the registered final subtraction.
// Operands are captured when a request is accepted, so the caller may change
// x/y/m while the op runs.
//
// Ports:
//   clk   in   1  single clock, rising edge
//   rst   in   1  synchronous reset, active-high
//   req   in   1  start request, accepted only when busy==0
//   x     in   K  multiplier (any value < 2^K)
//   y     in   K  multiplicand, y < m
//   m     in   K  odd modulus
//   busy  out  1  high while an op is in flight
//   res   out  K  result, valid with val, held until the next val
//   val   out  1  one-cycle done pulse
//   err   out  1  only with MM_R2MM_UN_MODCHK_EN: even-modulus flag, with val
//
// Optional feature macro: MM_R2MM_UN_MODCHK_EN (even-modulus check).
// -----------------------------------------------------------------------------
module mm_r2mm_un #(
    parameter int K = 2048,
    parameter int U = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req,
    input  logic [K-1:0] x,
    input  logic [K-1:0] y,
    input  logic [K-1:0] m,
    output logic         busy,
    output logic [K-1:0] res,
    output logic         val
`ifdef MM_R2MM_UN_MODCHK_EN
    ,
    output logic         err
`endif
);

    localparam int NCYC = K / U;
    localparam int CW   = $clog2(K / U) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SUB  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [K:0]    s_q, s_d;
    logic [K-1:0]  xr_q, xr_d;
    logic [K-1:0]  yr_q, yr_d;
    logic [K-1:0]  mr_q, mr_d;
    logic [K-1:0]  res_q, res_d;
    logic          val_q, val_d;
    logic          busy_q, busy_d;
    logic [K:0]    s_chain_s;
    logic          evenm_s;
`ifdef MM_R2MM_UN_MODCHK_EN
    logic          err_q, err_d;
`endif

    // One radix-2 step: t = S + xi*y, add m if odd, halve. K+2 bits holds
    // S + y + m because S < 2m and y < m.
    function automatic logic [K:0] mm_step(input logic [K:0]   s,
                                           input logic         xi,
                                           input logic [K-1:0] yv,
                                           input logic [K-1:0] mv);
        logic [K+1:0] t;
        t = {1'b0, s};
        if (xi) begin
            t = t + {2'b00, yv};
        end else begin
            t = t;
        end
        if (t[0]) begin
            t = t + {2'b00, mv};
        end else begin
            t = t;
        end
        return t[K+1:1];
    endfunction

    // Even-modulus detection is only active when the check is built in.
    always_comb begin
`ifdef MM_R2MM_UN_MODCHK_EN
        evenm_s = ~m[0];
`else
        evenm_s = 1'b0;
`endif
    end

    // Chain of U iterations; xr is shifted right each cycle so bit j is xi.
    always_comb begin
        s_chain_s = s_q;
        for (int j = 0; j < U; j++) begin
            s_chain_s = mm_step(s_chain_s, xr_q[j], yr_q, mr_q);
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        xr_d    = xr_q;
        yr_d    = yr_q;
        mr_d    = mr_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    xr_d    = x;
                    yr_d    = y;
                    mr_d    = m;
                    s_d     = '0;
                    cnt_d   = '0;
                    state_d = evenm_s ? SUB : RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                s_d   = s_chain_s;
                xr_d  = xr_q >> U;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(NCYC - 1)) begin
                    state_d = SUB;
                end else begin
                    state_d = RUN;
                end
            end
            SUB: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered outputs: final conditional subtraction, done pulse, busy.
    always_comb begin
        busy_d = (state_d != IDLE);
        val_d  = (state_q == SUB);
        res_d  = res_q;
`ifdef MM_R2MM_UN_MODCHK_EN
        err_d  = err_q;
`endif
        if (state_q == SUB) begin
            if (s_q >= {1'b0, mr_q}) begin
                res_d = K'(s_q - {1'b0, mr_q});
            end else begin
                res_d = s_q[K-1:0];
            end
`ifdef MM_R2MM_UN_MODCHK_EN
            // An even modulus never ran the iterations; report it as zero.
            err_d = ~mr_q[0];
            if (~mr_q[0]) begin
                res_d = '0;
            end else begin
                res_d = res_d;
            end
`endif
        end else begin
            res_d = res_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            s_q     <= '0;
            xr_q    <= '0;
            yr_q    <= '0;
            mr_q    <= '0;
            res_q   <= '0;
            val_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef MM_R2MM_UN_MODCHK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            xr_q    <= xr_d;
            yr_q    <= yr_d;
            mr_q    <= mr_d;
            res_q   <= res_d;
            val_q   <= val_d;
            busy_q  <= busy_d;
`ifdef MM_R2MM_UN_MODCHK_EN
            err_q   <= err_d;
`endif
        end
    end

    assign busy = busy_q;
    assign res  = res_q;
    assign val  = val_q;
`ifdef MM_R2MM_UN_MODCHK_EN
    assign err  = err_q;
`endif

endmodule
